bytebus_mem_responder: RTL and testbench
========================================

Name: bytebus_mem_responder

Overview:
Memory-side responder for the processor's 8-bit byte bus (memread, memwrite, adr, writedata, memdata).
- Serves each byte request from a synchronous 32-bit word SRAM.
- Adds a ready handshake so the processor FSM can stall.
- Keeps a one-word line buffer, so the four back-to-back FETCH byte reads of one instruction cost a single SRAM read.
- Writes go straight through to SRAM with byte enables.
- Sits between the mips core and the SRAM macro, replacing the behavioural external memory.

Parameters:
WIDTH, 8, byte address width; SRAM word address is WIDTH-2 bits.
CNTBITS, 16, width of the hit and miss statistics counters.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low (0 = reset)
memread  input  1  byte read request, held until ready
memwrite  input  1  byte write request, held until ready
adr  input  WIDTH  byte address: adr[1:0] selects the byte lane, adr[WIDTH-1:2] selects the word
writedata  input  8  write byte
memdata  output  8  read byte, valid when ready=1 and memread=1
ready  output  1  request completes this cycle
flush  input  1  synchronous: clear the line-buffer valid bit
sram_en  output  1  SRAM access strobe
sram_we  output  1  SRAM write (1) or read (0)
sram_adr  output  WIDTH-2  SRAM word address
sram_wdata  output  32  SRAM write word: writedata replicated on all 4 lanes
sram_bwe  output  4  byte-lane write enables, one-hot by adr[1:0]
sram_rdata  input  32  read word, valid the cycle after a read strobe
hit_count  output  CNTBITS  read hits, saturating
miss_count  output  CNTBITS  read misses, saturating

Behaviour:
- Byte lane mapping (little-endian): lane 0 = bits 7:0, lane 1 = 15:8, lane 2 = 23:16, lane 3 = 31:24.
- Line buffer contents: 32-bit data, WIDTH-2-bit tag, valid bit.
- Hit condition: valid & (tag == adr[WIDTH-1:2]).
- States: IDLE, FILL.

IDLE:
- memwrite=1:
  - Drive sram_en=1, sram_we=1, sram_adr=adr[WIDTH-1:2], sram_bwe=1<<adr[1:0]; ready=1 combinationally.
  - On a hit, the buffer byte at adr[1:0] is also updated at the clock edge.
  - Stay in IDLE. Counters are unchanged.
- memread=1 and hit:
  - ready=1; memdata = buffer byte at adr[1:0].
  - No SRAM access. hit_count increments. Stay in IDLE.
- memread=1 and miss:
  - ready=0; sram_en=1, sram_we=0, sram_adr = word address.
  - Latch the pending word address and byte lane. miss_count increments. Go to FILL.
- memread=1 and memwrite=1: write takes priority. The read is not counted and is served on a later cycle if memread is still held.
- Otherwise (no request): ready=0, sram_en=0.

FILL:
- Buffer loads sram_rdata; tag = pending word address; valid=1.
- ready=1; memdata = sram_rdata byte at the latched lane (forwarded, no extra cycle).
- No SRAM strobe. Return to IDLE.
- Requests are ignored in FILL; the requester must hold memread at the same adr.

Latency:
- Read hit: 1 cycle.
- Read miss: 2 cycles.
- Write: 1 cycle.

Other rules:
- When ready=0, memdata is 8'h00. memdata is never X.
- flush: clears valid at the next edge and takes priority over a fill load in the same cycle. A flush during FILL still forwards data (ready=1), but the buffer stays invalid.
- Counters saturate at all-ones and do not wrap.

Reset (reset=0, asynchronous):
- state=IDLE, valid=0, tag=0, data=0, hit_count=0, miss_count=0.
- Outputs: ready=0, memdata=0, sram_en=0, sram_we=0, sram_bwe=0, sram_adr=0, sram_wdata=0.
- Reset during FILL aborts the fill; the returning sram_rdata is discarded.
- Reset deassertion is synchronized externally; the block takes its first request on the first edge after reset=1.

Test Plan:
- Fill then hits: SRAM word 0x13 = 32'h8C_A2_00_4C; reads at adr 0x4C, 0x4D, 0x4E, 0x4F.
  -> First read: ready after 2 cycles, memdata=0x4C, one SRAM read strobe.
  -> Next three reads: 1 cycle each, data 0x00, 0xA2, 0x8C.
  -> hit_count=3, miss_count=1.
- Write hit merge: after the fill above, write 0x07 to adr 0x4D.
  -> sram_bwe=4'b0010, sram_wdata=32'h07070707, ready in the same cycle.
  -> Read of 0x4D returns 0x07 with no SRAM read.
- Write miss: write 0x55 to adr 0x10 with the buffer holding word 0x13.
  -> SRAM write issued; buffer tag still 0x13.
  -> Read of 0x10 misses (miss_count increments) and returns 0x55.
- Flush: flush=1 for one cycle, then read 0x4C.
  -> Miss, 2-cycle latency.
  -> Separately, flush during FILL: data forwarded, but the following read of the same word misses.
- Reset mid-fill: assert reset=0 in the FILL cycle.
  -> ready=0 and all counters 0 immediately.
  -> After release, a read of the same address misses again.
- Saturation and priority:
  -> With CNTBITS=2, issue 5 hits: hit_count stays at 3.
  -> memread=1 and memwrite=1 together: only an SRAM write occurs, and no counter changes that cycle.

Source files
------------

// File: rtl/bytebus_mem_responder_if.sv
// Processor-side byte bus bundle for the memory responder.
// master = mips core, slave = memory responder.
interface bytebus_mem_responder_if #(
    parameter int WIDTH = 8
);
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [7:0]       writedata;
    logic [7:0]       memdata;
    logic             ready;

    modport master (
        output memread, memwrite, adr, writedata,
        input  memdata, ready
    );

    modport slave (
        input  memread, memwrite, adr, writedata,
        output memdata, ready
    );
endinterface

// File: rtl/bytebus_mem_responder.sv
// Byte-bus responder over a 32-bit word SRAM with a one-word
// line buffer, write-through byte writes and hit/miss counters.
module bytebus_mem_responder #(
    parameter int WIDTH   = 8,
    parameter int CNTBITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    bytebus_mem_responder_if.slave bus,
    input  logic                   flush,
    output logic                   sram_en,
    output logic                   sram_we,
    output logic [WIDTH-3:0]       sram_adr,
    output logic [31:0]            sram_wdata,
    output logic [3:0]             sram_bwe,
    input  logic [31:0]            sram_rdata,
    output logic [CNTBITS-1:0]     hit_count,
    output logic [CNTBITS-1:0]     miss_count
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [WIDTH-3:0]   tag_q, tag_d;
    logic [31:0]        data_q, data_d;
    logic [WIDTH-3:0]   pend_q, pend_d;
    logic [1:0]         lane_q, lane_d;
    logic [CNTBITS-1:0] hit_q, hit_d;
    logic [CNTBITS-1:0] miss_q, miss_d;

    logic [WIDTH-3:0]   word;
    logic [1:0]         lane;
    logic               hit;

    assign word = bus.adr[WIDTH-1:2];
    assign lane = bus.adr[1:0];
    assign hit  = valid_q && (tag_q == word);

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    // Outputs are forced low while reset is held, not just after it.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        pend_d      = pend_q;
        lane_d      = lane_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        bus.ready   = 1'b0;
        bus.memdata = 8'h00;
        sram_en     = 1'b0;
        sram_we     = 1'b0;
        sram_adr    = '0;
        sram_wdata  = 32'h0;
        sram_bwe    = 4'b0000;
        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.memwrite) begin
                        bus.ready  = 1'b1;
                        sram_en    = 1'b1;
                        sram_we    = 1'b1;
                        sram_adr   = word;
                        sram_wdata = {4{bus.writedata}};
                        sram_bwe   = 4'b0001 << lane;
                        if (hit) begin
                            data_d[8*lane +: 8] = bus.writedata;
                        end
                    end else if (bus.memread) begin
                        if (hit) begin
                            bus.ready   = 1'b1;
                            bus.memdata = data_q[8*lane +: 8];
                            if (hit_q != '1) begin
                                hit_d = hit_q + 1'b1;
                            end
                        end else begin
                            sram_en = 1'b1;
                            sram_adr = word;
                            pend_d  = word;
                            lane_d  = lane;
                            state_d = FILL;
                            if (miss_q != '1) begin
                                miss_d = miss_q + 1'b1;
                            end
                        end
                    end
                end
                FILL: begin
                    bus.ready   = 1'b1;
                    bus.memdata = sram_rdata[8*lane_q +: 8];
                    data_d      = sram_rdata;
                    tag_d       = pend_q;
                    valid_d     = 1'b1;
                    state_d     = IDLE;
                end
            endcase
            // Flush wins over a fill landing in the same cycle.
            if (flush) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= 32'h0;
            pend_q  <= '0;
            lane_q  <= 2'b00;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            lane_q  <= lane_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end
endmodule

// File: tb/tb_bytebus_mem_responder.sv
// Directed bench for bytebus_mem_responder with a transaction-level
// line-buffer model and a word-array SRAM standing in for the macro.
module tb_bytebus_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    bytebus_mem_responder_if #(.WIDTH(8)) bus ();
    bytebus_mem_responder_if #(.WIDTH(8)) bus2 ();

    logic        sram_en, sram_we;
    logic [5:0]  sram_adr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [3:0]  sram_bwe;
    logic [15:0] hit_count, miss_count;

    logic        sram_en2, sram_we2;
    logic [5:0]  sram_adr2;
    logic [31:0] sram_wdata2;
    logic [31:0] sram_rdata2;
    logic [3:0]  sram_bwe2;
    logic [1:0]  hit_count2, miss_count2;

    bytebus_mem_responder #(.WIDTH(8), .CNTBITS(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .flush(flush),
        .sram_en(sram_en), .sram_we(sram_we), .sram_adr(sram_adr),
        .sram_wdata(sram_wdata), .sram_bwe(sram_bwe),
        .sram_rdata(sram_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    bytebus_mem_responder #(.WIDTH(8), .CNTBITS(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .flush(1'b0),
        .sram_en(sram_en2), .sram_we(sram_we2), .sram_adr(sram_adr2),
        .sram_wdata(sram_wdata2), .sram_bwe(sram_bwe2),
        .sram_rdata(sram_rdata2),
        .hit_count(hit_count2), .miss_count(miss_count2)
    );

    assign sram_rdata2 = 32'h8CA2004C;

    int checks = 0;
    int failures = 0;
    int rd_strobes = 0;
    logic cmp_en = 1'b0;

    logic [31:0] mem [64];

    // Word SRAM: one-cycle read latency, byte-lane writes.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int k = 0; k < 4; k++) begin
                    if (sram_bwe[k]) mem[sram_adr][8*k +: 8] <= sram_wdata[8*k +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_adr];
                rd_strobes++;
            end
        end
    end

    // Transaction-level model of the line buffer and counters.
    logic       mvalid = 1'b0;
    logic [5:0] mtag = 6'd0;
    int         mhits = 0;
    int         mmiss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [7:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    // A completed read must return what memory holds; idle data is zero.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (!bus.ready) begin
                chk("memdata_when_not_ready", {24'h0, bus.memdata}, 32'h0);
            end else if (bus.memread && !bus.memwrite) begin
                chk("memdata_vs_memory", {24'h0, bus.memdata}, {24'h0, ref_byte(bus.adr)});
                chk("no_strobe_on_data_cycle", {31'h0, sram_en}, 32'h0);
            end
        end
    end

    task automatic do_read(input logic [7:0] a, output int lat, output logic [7:0] d);
        bus.memread = 1'b1;
        bus.adr = a;
        lat = 0;
        d = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                lat = i;
                d = bus.memdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.memread = 1'b0;
    endtask

    task automatic read_chk(input logic [7:0] a, input logic [7:0] exp_d, input string name);
        logic exp_hit;
        int lat, s0;
        logic [7:0] d;
        exp_hit = mvalid && (mtag == a[7:2]);
        s0 = rd_strobes;
        do_read(a, lat, d);
        chk({name, "_latency"}, lat, exp_hit ? 1 : 2);
        chk({name, "_data"}, {24'h0, d}, {24'h0, exp_d});
        chk({name, "_sram_reads"}, rd_strobes - s0, exp_hit ? 0 : 1);
        if (exp_hit) begin
            mhits++;
        end else begin
            mmiss++;
            mvalid = 1'b1;
            mtag = a[7:2];
        end
        chk({name, "_hit_count"}, {16'h0, hit_count}, mhits);
        chk({name, "_miss_count"}, {16'h0, miss_count}, mmiss);
    endtask

    task automatic write_chk(input logic [7:0] a, input logic [7:0] wd,
                             input logic [3:0] exp_bwe, input logic [31:0] exp_wdata,
                             input string name);
        bus.memwrite = 1'b1;
        bus.adr = a;
        bus.writedata = wd;
        @(negedge clk);
        chk({name, "_ready"}, {31'h0, bus.ready}, 32'h1);
        chk({name, "_sram_en"}, {31'h0, sram_en}, 32'h1);
        chk({name, "_sram_we"}, {31'h0, sram_we}, 32'h1);
        chk({name, "_sram_adr"}, {26'h0, sram_adr}, {26'h0, a[7:2]});
        chk({name, "_bwe"}, {28'h0, sram_bwe}, {28'h0, exp_bwe});
        chk({name, "_wdata"}, sram_wdata, exp_wdata);
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        chk({name, "_hit_count"}, {16'h0, hit_count}, mhits);
        chk({name, "_miss_count"}, {16'h0, miss_count}, mmiss);
    endtask

    initial begin
        bus.memread = 1'b0;
        bus.memwrite = 1'b0;
        bus.adr = 8'h00;
        bus.writedata = 8'h00;
        bus2.memread = 1'b0;
        bus2.memwrite = 1'b0;
        bus2.adr = 8'h00;
        bus2.writedata = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h13] = 32'h8CA2004C;
        mem[6'h04] = 32'h11223344;

        #2;
        chk("rst_ready", {31'h0, bus.ready}, 32'h0);
        chk("rst_memdata", {24'h0, bus.memdata}, 32'h0);
        chk("rst_sram_en", {31'h0, sram_en}, 32'h0);
        chk("rst_sram_we", {31'h0, sram_we}, 32'h0);
        chk("rst_sram_adr", {26'h0, sram_adr}, 32'h0);
        chk("rst_sram_bwe", {28'h0, sram_bwe}, 32'h0);
        chk("rst_sram_wdata", sram_wdata, 32'h0);
        chk("rst_hit_count", {16'h0, hit_count}, 32'h0);
        chk("rst_miss_count", {16'h0, miss_count}, 32'h0);

        @(posedge clk);
        #1;
        reset = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;

        read_chk(8'h4C, 8'h4C, "fill_4c");
        read_chk(8'h4D, 8'h00, "hit_4d");
        read_chk(8'h4E, 8'hA2, "hit_4e");
        read_chk(8'h4F, 8'h8C, "hit_4f");
        chk("fill_hits_literal", {16'h0, hit_count}, 32'd3);
        chk("fill_miss_literal", {16'h0, miss_count}, 32'd1);
        chk("fill_one_sram_read", rd_strobes, 32'd1);

        write_chk(8'h4D, 8'h07, 4'b0010, 32'h07070707, "wr_hit");
        read_chk(8'h4D, 8'h07, "merge_4d");

        write_chk(8'h10, 8'h55, 4'b0001, 32'h55555555, "wr_miss");
        read_chk(8'h4C, 8'h4C, "tag_kept_4c");
        read_chk(8'h10, 8'h55, "miss_10");
        chk("miss_10_literal", {16'h0, miss_count}, 32'd2);

        read_chk(8'h4C, 8'h4C, "refill_4c");
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        mvalid = 1'b0;
        read_chk(8'h4D, 8'h07, "post_flush_4d");

        bus.memread = 1'b1;
        bus.adr = 8'h10;
        @(negedge clk);
        chk("ff_first_cycle_ready", {31'h0, bus.ready}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("ff_fill_ready", {31'h0, bus.ready}, 32'h1);
        chk("ff_fill_data", {24'h0, bus.memdata}, 32'h55);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.memread = 1'b0;
        mmiss++;
        mvalid = 1'b0;
        chk("ff_miss_count", {16'h0, miss_count}, mmiss);
        read_chk(8'h11, 8'h33, "after_ff_11");

        bus.memread = 1'b1;
        bus.memwrite = 1'b1;
        bus.adr = 8'h12;
        bus.writedata = 8'h9A;
        @(negedge clk);
        chk("prio_ready", {31'h0, bus.ready}, 32'h1);
        chk("prio_sram_en", {31'h0, sram_en}, 32'h1);
        chk("prio_sram_we", {31'h0, sram_we}, 32'h1);
        chk("prio_bwe", {28'h0, sram_bwe}, 32'h4);
        @(posedge clk);
        #1;
        bus.memwrite = 1'b0;
        chk("prio_hit_count", {16'h0, hit_count}, mhits);
        chk("prio_miss_count", {16'h0, miss_count}, mmiss);
        read_chk(8'h12, 8'h9A, "prio_read_12");

        bus.memread = 1'b1;
        bus.adr = 8'h4C;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rstfill_ready", {31'h0, bus.ready}, 32'h0);
        chk("rstfill_memdata", {24'h0, bus.memdata}, 32'h0);
        chk("rstfill_sram_en", {31'h0, sram_en}, 32'h0);
        chk("rstfill_hit_count", {16'h0, hit_count}, 32'h0);
        chk("rstfill_miss_count", {16'h0, miss_count}, 32'h0);
        bus.memread = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mhits = 0;
        mmiss = 0;
        mvalid = 1'b0;
        read_chk(8'h4C, 8'h4C, "post_reset_4c");

        bus2.memread = 1'b1;
        bus2.adr = 8'h4C;
        repeat (7) @(posedge clk);
        #1;
        bus2.memread = 1'b0;
        chk("sat_hit_count", {30'h0, hit_count2}, 32'd3);
        chk("sat_miss_count", {30'h0, miss_count2}, 32'd1);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
